ej32_pf: RTL

- Instruction prefetch stage that sits directly upstream of the eJ32 decoder.
- Issues aligned 32-bit reads on the instruction memory port.
- Splits each returned word into bytes in big-endian (JVM) order and queues them in a byte FIFO.
- Presents the head byte and its address to the decoder, pops one byte per advance, and flushes/redirects on taken branches, calls and returns.

---
 rtl/ej32_pkg.sv | 20 ++
 rtl/ej32_pf_if.sv | 25 ++
 rtl/ej32_pf_fifo.sv | 48 ++++
 rtl/ej32_pf.sv | 113 +++++++++++
 4 files changed

// File: rtl/ej32_pkg.sv
// Shared eJ32 types and helpers used by the instruction prefetch stage.
package ej32_pkg;

  typedef enum logic [1:0] {PF_IDLE, PF_REQ, PF_DROP} pf_st_t;

  localparam int unsigned PF_WORD = 4;

  // Byte at offset 'off' of a big-endian (JVM order) word; offset 0 is the MSB.
  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] off);
    logic [7:0] b;
    unique case (off)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ej32_pf_if.sv
// Memory read port and decoder-facing byte stream of the prefetch stage.
interface ej32_pf_if #(
  parameter int unsigned A_W = 17
);
  logic           mem_req;
  logic [A_W-1:0] mem_addr;
  logic           mem_ack;
  logic [31:0]    mem_rdata;
  logic           pf_v;
  logic [7:0]     pf_data;
  logic [A_W-1:0] pf_p;
  logic           pf_adv;
  logic           redir;
  logic [A_W-1:0] redir_tgt;

  modport master (
    output mem_req, mem_addr, pf_v, pf_data, pf_p,
    input  mem_ack, mem_rdata, pf_adv, redir, redir_tgt
  );

  modport slave (
    input  mem_req, mem_addr, pf_v, pf_data, pf_p,
    output mem_ack, mem_rdata, pf_adv, redir, redir_tgt
  );
endinterface

// File: rtl/ej32_pf_fifo.sv
// Byte queue: pushes up to four big-endian bytes of a word per cycle, pops one.
module ej32_pf_fifo import ej32_pkg::*; #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [2:0]             push_n,
  input  logic [1:0]             push_off,
  input  logic [31:0]            push_data,
  input  logic                   pop,
  output logic [7:0]             rd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   count_q;
  logic          pop_ok;

  assign pop_ok = pop && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Bytes push_off..push_off+push_n-1 of the word land at consecutive tail slots.
      for (int i = 0; i < int'(PF_WORD); i++) begin
        if (3'(i) < push_n) mem_q[tail_q + PW'(i)] <= be_byte(push_data, push_off + 2'(i));
      end
      head_q  <= head_q + PW'(pop_ok);
      tail_q  <= tail_q + PW'(push_n);
      count_q <= count_q + (PW+1)'(push_n) - (PW+1)'(pop_ok);
    end
  end

  assign rd_data = mem_q[head_q];
  assign count   = count_q;

endmodule

// File: rtl/ej32_pf.sv
// eJ32 instruction prefetch: aligned word fetch, big-endian byte split, redirect/flush.
module ej32_pf import ej32_pkg::*; #(
  parameter int unsigned   A_W   = 17,
  parameter logic [A_W-1:0] COLD = '0,
  parameter int unsigned   DEPTH = 8
) (
  input logic        clk,
  input logic        rst,
  ej32_pf_if.master  bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  pf_st_t         st_q;
  logic           mem_req_q;
  logic [A_W-1:0] mem_addr_q;
  logic [A_W-3:0] fw_q;       // fetch pointer, word part
  logic [A_W-3:0] fw_nxt;
  logic [1:0]     sk_q;       // bytes to skip in the next returned word
  logic [A_W-1:0] pf_p_q;
  logic [CW-1:0]  count, count_nxt;
  logic [2:0]     push_n;
  logic           ack_ok, pop, room_now, room_nxt;

  always_comb begin
    ack_ok    = (st_q == PF_REQ) && bus.mem_ack && !bus.redir;
    push_n    = ack_ok ? 3'(PF_WORD) - {1'b0, sk_q} : 3'd0;
    pop       = bus.pf_adv && (count != '0) && !bus.redir;
    count_nxt = count + CW'(push_n) - CW'(pop);
    room_now  = 32'(count) + PF_WORD <= DEPTH;
    room_nxt  = 32'(count_nxt) + PF_WORD <= DEPTH;
    fw_nxt    = fw_q + (A_W-2)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= PF_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= {COLD[A_W-1:2], 2'b00};
      fw_q       <= COLD[A_W-1:2];
      sk_q       <= COLD[1:0];
      pf_p_q     <= COLD;
    end else begin
      if (bus.redir) pf_p_q <= bus.redir_tgt;
      else if (pop)  pf_p_q <= pf_p_q + 1'b1;

      if (bus.redir) begin
        fw_q <= bus.redir_tgt[A_W-1:2];
        sk_q <= bus.redir_tgt[1:0];
      end else if (ack_ok) begin
        fw_q <= fw_nxt;
        sk_q <= 2'd0;
      end

      unique case (st_q)
        PF_IDLE: begin
          if (!bus.redir && room_now) begin
            st_q       <= PF_REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {fw_q, 2'b00};
          end
        end
        PF_REQ: begin
          if (bus.redir) begin
            // An ack coinciding with the redirect closes the bus cycle right away.
            if (bus.mem_ack) begin
              st_q      <= PF_IDLE;
              mem_req_q <= 1'b0;
            end else begin
              st_q <= PF_DROP;
            end
          end else if (bus.mem_ack) begin
            if (room_nxt) begin
              mem_addr_q <= {fw_nxt, 2'b00};
            end else begin
              st_q      <= PF_IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        PF_DROP: begin
          if (bus.mem_ack) begin
            st_q      <= PF_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          st_q      <= PF_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  ej32_pf_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redir),
    .push_n   (push_n),
    .push_off (sk_q),
    .push_data(bus.mem_rdata),
    .pop      (pop),
    .rd_data  (bus.pf_data),
    .count    (count)
  );

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.pf_v     = (count != '0);
  assign bus.pf_p     = pf_p_q;

endmodule
